// File: rtl/axi_lite_ram_slave.sv
// axi_lite_ram_slave
// ------------------
// AXI4-Lite responder RAM. This is the default memory target on the SoC
// interconnect, and it serves the data/instruction traffic of cpu_top.
// Storage is word organised. Writes honour per-byte strobes. The read and
// write channels run independently of each other.
//
// Optional feature (compile-time macro MERO_RAM_ERR_EN):
//   When the macro is defined, an address that has any bit set above bit
//   log2(DEPTH)+1 is out of range:
//     - a write leaves the RAM untouched and returns DECERR;
//     - a read returns zero data and DECERR.
//   When the macro is undefined, upper address bits are ignored and such
//   addresses alias onto the array.
//
// Parameters:
//   ADDR_W : byte address width
//   DATA_W : data width (fixed at 32); strobe width is DATA_W/8
//   DEPTH  : number of words (power of two, at most 2^(ADDR_W-2))
//
// Ports:
//   clk_i, rst_i            : clock (rising edge), synchronous active-low reset
//   s_aw* / s_w* / s_b*     : write address, write data, write response channels
//   s_ar* / s_r*            : read address, read data channels
//   All ready/valid/data/response outputs come straight from registers.
module axi_lite_ram_slave #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_W-1:0]     s_awaddr_i,
  input  logic                  s_awvalid_i,
  output logic                  s_awready_o,
  input  logic [DATA_W-1:0]     s_wdata_i,
  input  logic [DATA_W/8-1:0]   s_wstrb_i,
  input  logic                  s_wvalid_i,
  output logic                  s_wready_o,
  output logic [1:0]            s_bresp_o,
  output logic                  s_bvalid_o,
  input  logic                  s_bready_i,
  input  logic [ADDR_W-1:0]     s_araddr_i,
  input  logic                  s_arvalid_i,
  output logic                  s_arready_o,
  output logic [DATA_W-1:0]     s_rdata_o,
  output logic [1:0]            s_rresp_o,
  output logic                  s_rvalid_o,
  input  logic                  s_rready_i
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int STRB_W = DATA_W / 8;

`ifdef MERO_RAM_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [0:0] {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } w_state_t;

  // R_ADDR is the one cycle in which the latched address reads the array.
  typedef enum logic [1:0] {
    R_IDLE = 2'b00,
    R_ADDR = 2'b01,
    R_DATA = 2'b10
  } r_state_t;

  // Storage
  logic [DATA_W-1:0] ram_mem [DEPTH];

  // Write channel state
  w_state_t            w_state_r, w_state_s;
  logic                aw_full_r, aw_full_s;
  logic                w_full_r, w_full_s;
  logic [IDX_W-1:0]    aw_idx_r, aw_idx_s;
  logic                aw_oor_r, aw_oor_s;
  logic [DATA_W-1:0]   wdata_r, wdata_s;
  logic [STRB_W-1:0]   wstrb_r, wstrb_s;
  logic                awready_r, awready_s;
  logic                wready_r, wready_s;
  logic                bvalid_r, bvalid_s;
  logic [1:0]          bresp_r, bresp_s;
  logic                ram_we_s;
  logic                aw_hs_s, w_hs_s;
  logic                aw_in_oor_s;

  // Read channel state
  r_state_t            r_state_r, r_state_s;
  logic [IDX_W-1:0]    ar_idx_r, ar_idx_s;
  logic                ar_oor_r, ar_oor_s;
  logic                arready_r, arready_s;
  logic                rvalid_r, rvalid_s;
  logic [1:0]          rresp_r, rresp_s;
  logic [DATA_W-1:0]   rdata_r;
  logic                ram_re_s;
  logic                ar_hs_s;
  logic                ar_in_oor_s;

  // Handshakes only ever see registered readies, so no output depends on an input.
  assign aw_hs_s = s_awvalid_i & awready_r;
  assign w_hs_s  = s_wvalid_i  & wready_r;
  assign ar_hs_s = s_arvalid_i & arready_r;

  // Out-of-range means any bit set above the word index. ERR_EN is 0 when the
  // feature is off, which turns this into aliasing.
  assign aw_in_oor_s = ERR_EN & (|(s_awaddr_i >> (IDX_W + 2)));
  assign ar_in_oor_s = ERR_EN & (|(s_araddr_i >> (IDX_W + 2)));

  // Write FSM next state: buffer AW/W, commit once both are held, then wait for B.
  always_comb begin
    w_state_s = w_state_r;
    aw_full_s = aw_full_r;
    w_full_s  = w_full_r;
    aw_idx_s  = aw_idx_r;
    aw_oor_s  = aw_oor_r;
    wdata_s   = wdata_r;
    wstrb_s   = wstrb_r;
    awready_s = awready_r;
    wready_s  = wready_r;
    bvalid_s  = bvalid_r;
    bresp_s   = bresp_r;
    ram_we_s  = 1'b0;
    case (w_state_r)
      W_IDLE: begin
        if (aw_full_r && w_full_r) begin
          // Commit edge. Both readies are already low, so nothing new is captured here.
          ram_we_s  = ~aw_oor_r;
          bvalid_s  = 1'b1;
          bresp_s   = aw_oor_r ? RESP_DECERR : RESP_OKAY;
          aw_full_s = 1'b0;
          w_full_s  = 1'b0;
          awready_s = 1'b0;
          wready_s  = 1'b0;
          w_state_s = W_RESP;
        end else begin
          if (aw_hs_s) begin
            aw_full_s = 1'b1;
            aw_idx_s  = s_awaddr_i[IDX_W+1:2];
            aw_oor_s  = aw_in_oor_s;
          end else begin
            aw_full_s = aw_full_r;
          end
          if (w_hs_s) begin
            w_full_s = 1'b1;
            wdata_s  = s_wdata_i;
            wstrb_s  = s_wstrb_i;
          end else begin
            w_full_s = w_full_r;
          end
          // Each ready drops on the edge after its beat is captured.
          awready_s = ~aw_full_s;
          wready_s  = ~w_full_s;
        end
      end
      W_RESP: begin
        if (s_bready_i) begin
          bvalid_s  = 1'b0;
          awready_s = 1'b1;
          wready_s  = 1'b1;
          w_state_s = W_IDLE;
        end else begin
          bvalid_s  = 1'b1;
          awready_s = 1'b0;
          wready_s  = 1'b0;
        end
      end
      default: begin
        w_state_s = W_IDLE;
        aw_full_s = 1'b0;
        w_full_s  = 1'b0;
        awready_s = 1'b0;
        wready_s  = 1'b0;
        bvalid_s  = 1'b0;
        bresp_s   = RESP_OKAY;
      end
    endcase
  end

  // Write FSM registers, including the AW/W holding buffers and B outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      w_state_r <= W_IDLE;
      aw_full_r <= 1'b0;
      w_full_r  <= 1'b0;
      aw_idx_r  <= {IDX_W{1'b0}};
      aw_oor_r  <= 1'b0;
      wdata_r   <= {DATA_W{1'b0}};
      wstrb_r   <= {STRB_W{1'b0}};
      awready_r <= 1'b0;
      wready_r  <= 1'b0;
      bvalid_r  <= 1'b0;
      bresp_r   <= RESP_OKAY;
    end else begin
      w_state_r <= w_state_s;
      aw_full_r <= aw_full_s;
      w_full_r  <= w_full_s;
      aw_idx_r  <= aw_idx_s;
      aw_oor_r  <= aw_oor_s;
      wdata_r   <= wdata_s;
      wstrb_r   <= wstrb_s;
      awready_r <= awready_s;
      wready_r  <= wready_s;
      bvalid_r  <= bvalid_s;
      bresp_r   <= bresp_s;
    end
  end

  // RAM byte-strobed write port. The array itself is never reset, but a
  // commit that coincides with reset is dropped.
  always_ff @(posedge clk_i) begin
    if (rst_i && ram_we_s) begin
      for (int b = 32'sd0; b < STRB_W; b++) begin
        if (wstrb_r[b]) begin
          ram_mem[aw_idx_r][8*b +: 8] <= wdata_r[8*b +: 8];
        end
      end
    end
  end

  // Read FSM next state: latch AR, read the array on the next edge, hold R until accepted.
  always_comb begin
    r_state_s = r_state_r;
    ar_idx_s  = ar_idx_r;
    ar_oor_s  = ar_oor_r;
    arready_s = arready_r;
    rvalid_s  = rvalid_r;
    rresp_s   = rresp_r;
    ram_re_s  = 1'b0;
    case (r_state_r)
      R_IDLE: begin
        if (ar_hs_s) begin
          ar_idx_s  = s_araddr_i[IDX_W+1:2];
          ar_oor_s  = ar_in_oor_s;
          arready_s = 1'b0;
          r_state_s = R_ADDR;
        end else begin
          arready_s = 1'b1;
        end
      end
      R_ADDR: begin
        ram_re_s  = 1'b1;
        rvalid_s  = 1'b1;
        rresp_s   = ar_oor_r ? RESP_DECERR : RESP_OKAY;
        arready_s = 1'b0;
        r_state_s = R_DATA;
      end
      R_DATA: begin
        if (s_rready_i) begin
          rvalid_s  = 1'b0;
          arready_s = 1'b1;
          r_state_s = R_IDLE;
        end else begin
          rvalid_s  = 1'b1;
          arready_s = 1'b0;
        end
      end
      default: begin
        r_state_s = R_IDLE;
        arready_s = 1'b0;
        rvalid_s  = 1'b0;
        rresp_s   = RESP_OKAY;
      end
    endcase
  end

  // Read FSM registers and R-channel control outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state_r <= R_IDLE;
      ar_idx_r  <= {IDX_W{1'b0}};
      ar_oor_r  <= 1'b0;
      arready_r <= 1'b0;
      rvalid_r  <= 1'b0;
      rresp_r   <= RESP_OKAY;
    end else begin
      r_state_r <= r_state_s;
      ar_idx_r  <= ar_idx_s;
      ar_oor_r  <= ar_oor_s;
      arready_r <= arready_s;
      rvalid_r  <= rvalid_s;
      rresp_r   <= rresp_s;
    end
  end

  // Read data register. It samples the array with a non-blocking read, so a
  // commit to the same word on the same edge is not yet visible
  // (read-before-write).
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      rdata_r <= {DATA_W{1'b0}};
    end else if (ram_re_s) begin
      rdata_r <= ar_oor_r ? {DATA_W{1'b0}} : ram_mem[ar_idx_r];
    end else begin
      rdata_r <= rdata_r;
    end
  end

  assign s_awready_o = awready_r;
  assign s_wready_o  = wready_r;
  assign s_bvalid_o  = bvalid_r;
  assign s_bresp_o   = bresp_r;
  assign s_arready_o = arready_r;
  assign s_rvalid_o  = rvalid_r;
  assign s_rresp_o   = rresp_r;
  assign s_rdata_o   = rdata_r;

endmodule
